fb_pixel_writer: RTL and testbench

Parametrised successor pixel writer for the DE10 GPU. It sits between the rasteriser and the HPS DDR3 Avalon-MM write port. It buffers {x, y, colour} pixel records in an internal FIFO and issues single-pixel masked 64-bit writes into one of two framebuffers. It also performs burst-mode background fill and, optionally, clips off-screen pixels.

---
 rtl/fb_pixel_writer.sv | 196 +++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// Pixel FIFO feeding masked single-word DDR3 writes plus burst background fill.
// Define FB_PIXEL_WRITER_CLIP_EN to discard off-screen pixels and count them.
module fb_pixel_writer #(
    parameter int unsigned       ADDR_W     = 29,
    parameter int unsigned       FB_WIDTH   = 640,
    parameter int unsigned       FB_HEIGHT  = 480,
    parameter logic [ADDR_W-1:0] FB0_BASE   = 29'h0700_0000,
    parameter logic [ADDR_W-1:0] FB1_BASE   = 29'h0702_5800,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter int unsigned       FILL_BURST = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] avm_address,
    output logic [7:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    output logic [63:0]       avm_writedata,
    output logic [7:0]        avm_byteenable,
    output logic              avm_write,
    input  logic [63:0]       pixel_in,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    input  logic              buffer_sel,
    input  logic              fill_start,
    input  logic [31:0]       fill_colour,
    output logic              busy,
    output logic              fill_done,
    output logic [15:0]       dropped_count
);

    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned TOTAL_WORDS = FB_WIDTH * FB_HEIGHT / 2;
    localparam logic [7:0]  LAST_BEAT   = 8'(FILL_BURST - 1);

    typedef enum logic [1:0] {IDLE, PIX_WAIT, FILL_BEAT} state_t;

    state_t state, state_nxt;

    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             empty, full, push, pop;

    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, sel_base, pix_off;
    logic [7:0]        burst_q, burst_d, be_q, be_d, beat_q, beat_d;
    logic [63:0]       data_q, data_d, head;
    logic              write_q, write_d, done_q, done_d;
    logic [31:0]       idx_q, idx_d, idx_inc, lin;
    logic [15:0]       drop_q, drop_d, hx, hy;
    logic [31:0]       hc;
    logic              oob, last_word;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pixel_ready = reset_n && !full;
    assign push        = pixel_valid && pixel_ready;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= pixel_in;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head     = mem[rd_ptr[PTR_W-1:0]];
    assign hx       = head[63:48];
    assign hy       = head[47:32];
    assign hc       = head[31:0];
    assign lin      = ({16'h0, hy} * FB_WIDTH + {16'h0, hx}) >> 1;
    assign pix_off  = lin[ADDR_W-1:0];
    assign sel_base = buffer_sel ? FB1_BASE : FB0_BASE;

`ifdef FB_PIXEL_WRITER_CLIP_EN
    assign oob = (32'(hx) >= FB_WIDTH) || (32'(hy) >= FB_HEIGHT);
`else
    assign oob = 1'b0;
`endif

    assign idx_inc   = idx_q + 1'b1;
    assign last_word = (idx_q == TOTAL_WORDS - 1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            burst_q <= 8'd1;
            be_q    <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            base_q  <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            drop_q  <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            be_q    <= be_d;
            data_q  <= data_d;
            write_q <= write_d;
            done_q  <= done_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fill_start) state_nxt = FILL_BEAT;
                       else if (!empty && !oob) state_nxt = PIX_WAIT;
            PIX_WAIT:  if (!avm_waitrequest) state_nxt = IDLE;
            FILL_BEAT: if (!avm_waitrequest && last_word) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered, so this block computes their next-cycle values.
    always_comb begin
        addr_d  = addr_q;
        burst_d = burst_q;
        be_d    = be_q;
        data_d  = data_q;
        write_d = write_q;
        done_d  = 1'b0;
        base_d  = base_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        drop_d  = drop_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    base_d  = sel_base;
                    addr_d  = sel_base;
                    idx_d   = '0;
                    beat_d  = '0;
                    burst_d = 8'(FILL_BURST);
                    be_d    = 8'hFF;
                    data_d  = {fill_colour, fill_colour};
                    write_d = 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                    if (oob) begin
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
                    end else begin
                        addr_d  = sel_base + pix_off;
                        burst_d = 8'd1;
                        be_d    = hx[0] ? 8'hF0 : 8'h0F;
                        data_d  = hx[0] ? {hc, 32'h0} : {32'h0, hc};
                        write_d = 1'b1;
                    end
                end
            end
            PIX_WAIT: if (!avm_waitrequest) write_d = 1'b0;
            FILL_BEAT: begin
                if (!avm_waitrequest) begin
                    if (last_word) begin
                        write_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        // Address advances only at burst boundaries; it stays put within a burst.
                        if (beat_q == LAST_BEAT) begin
                            beat_d = '0;
                            addr_d = base_q + idx_inc[ADDR_W-1:0];
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign avm_address    = addr_q;
    assign avm_burstcount = burst_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = data_q;
    assign avm_write      = write_q;
    assign busy           = (state != IDLE);
    assign fill_done      = done_q;
    assign dropped_count  = drop_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: vector table, hand-written corner
// sequences and randomized pixels against an arithmetic framebuffer model.
module tb_fb_pixel_writer;

    localparam int unsigned W        = 640;
    localparam int unsigned H        = 8;
    localparam logic [28:0] FB0      = 29'h0700_0000;
    localparam logic [28:0] FB1      = 29'h0702_5800;
    localparam int unsigned WORDS    = W * H / 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [28:0] avm_address;
    logic [7:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;
    logic [63:0] avm_writedata;
    logic [7:0]  avm_byteenable;
    logic        avm_write;
    logic [63:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        buffer_sel = 1'b0;
    logic        fill_start = 1'b0;
    logic [31:0] fill_colour = '0;
    logic        busy;
    logic        fill_done;
    logic [15:0] dropped_count;

    fb_pixel_writer #(
        .ADDR_W(29), .FB_WIDTH(W), .FB_HEIGHT(H), .FB0_BASE(FB0), .FB1_BASE(FB1),
        .FIFO_DEPTH(16), .FILL_BURST(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .avm_address(avm_address),
        .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_write(avm_write), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .buffer_sel(buffer_sel), .fill_start(fill_start),
        .fill_colour(fill_colour), .busy(busy), .fill_done(fill_done),
        .dropped_count(dropped_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  bc;
        logic [7:0]  be;
        logic [63:0] data;
    } txn_t;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] c;
        logic        sel;
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } vec_t;

    txn_t acc[$];
    txn_t expq[$];
    int   wait_mode = 0;
    int   done_cnt = 0;
    int   passed = 0;
    int   total = 0;

    // Slave model: chooses waitrequest each cycle and logs every accepted beat.
    initial forever begin
        @(negedge clock);
        case (wait_mode)
            0:       avm_waitrequest = 1'b0;
            1:       avm_waitrequest = ($urandom_range(0, 2) == 0);
            default: avm_waitrequest = 1'b1;
        endcase
        if (reset_n && avm_write && !avm_waitrequest)
            acc.push_back('{avm_address, avm_burstcount, avm_byteenable, avm_writedata});
        if (reset_n && fill_done) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic txn_t model(input int x, input int y, input logic [31:0] c, input logic sel);
        txn_t t;
        int unsigned off;
        off    = (y * W + x) / 2;
        t.addr = (sel ? FB1 : FB0) + 29'(off);
        t.bc   = 8'd1;
        t.be   = (x % 2 == 1) ? 8'hF0 : 8'h0F;
        t.data = (x % 2 == 1) ? {c, 32'h0} : {32'h0, c};
        return t;
    endfunction

    function automatic bit clipped(input int x, input int y);
`ifdef FB_PIXEL_WRITER_CLIP_EN
        return (x >= W) || (y >= H);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] pix(input int x, input int y, input logic [31:0] c);
        return {16'(x), 16'(y), c};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        acc.delete();
        done_cnt = 0;
    endtask

    task automatic push(input logic [63:0] p, output bit ok);
        pixel_in    = p;
        pixel_valid = 1'b1;
        @(negedge clock);
        ok = pixel_ready;
        @(posedge clock);
        #1;
        pixel_valid = 1'b0;
    endtask

    task automatic push_retry(input logic [63:0] p, input int budget, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (!ok && k < budget) begin
            push(p, ok);
            k++;
        end
        if (!ok) check("push_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check(name, 64'(acc.size()), 64'(n));
        @(posedge clock);
        #1;
    endtask

    vec_t vt[5];

    initial begin
        bit   ok;
        txn_t e;
        int   first_refuse;
        int   n_acc;
        int   drop_exp;
        int   addr_err;
        int   data_err;

        vt[0] = '{3,   2, 32'hAABBCCDD, 1'b0, 29'h0700_0281, 8'hF0, 64'hAABBCCDD_00000000};
        vt[1] = '{0,   0, 32'h11223344, 1'b1, 29'h0702_5800, 8'h0F, 64'h00000000_11223344};
        vt[2] = '{639, 7, 32'hCAFEF00D, 1'b0, 29'h0700_09FF, 8'hF0, 64'hCAFEF00D_00000000};
        vt[3] = '{2,   1, 32'h0BADBEEF, 1'b1, 29'h0702_5941, 8'h0F, 64'h00000000_0BADBEEF};
        vt[4] = '{1,   0, 32'h12345678, 1'b0, 29'h0700_0000, 8'hF0, 64'h12345678_00000000};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_burst", 64'(avm_burstcount), 64'd1);
        check("rst_be", 64'(avm_byteenable), 64'd0);
        check("rst_data", avm_writedata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(fill_done), 64'd0);
        check("rst_drop", 64'(dropped_count), 64'd0);
        check("rst_ready_low", 64'(pixel_ready), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready_high", 64'(pixel_ready), 64'd1);
        idle(1);

        // Vector table, zero wait
        for (int i = 0; i < 5; i++) begin
            acc.delete();
            buffer_sel = vt[i].sel;
            push_retry(pix(vt[i].x, vt[i].y, vt[i].c), 20, ok);
            wait_acc(1, 50, $sformatf("vec%0d_count", i));
            if (acc.size() > 0) begin
                check($sformatf("vec%0d_addr", i), 64'(acc[0].addr), 64'(vt[i].addr));
                check($sformatf("vec%0d_be", i), 64'(acc[0].be), 64'(vt[i].be));
                check($sformatf("vec%0d_data", i), acc[0].data, vt[i].data);
                check($sformatf("vec%0d_bc", i), 64'(acc[0].bc), 64'd1);
            end
            idle(3);
        end

        // Latency and hold under waitrequest
        acc.delete();
        buffer_sel = 1'b1;
        wait_mode  = 2;
        e = model(0, 0, 32'h5A5A_A5A5, 1'b1);
        push(pix(0, 0, 32'h5A5A_A5A5), ok);
        check("wait_push_ok", 64'(ok), 64'd1);
        @(negedge clock);
        check("lat_write_not_yet", 64'(avm_write), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("hold%0d_write", i), 64'(avm_write), 64'd1);
            check($sformatf("hold%0d_addr", i), 64'(avm_address), 64'(e.addr));
            check($sformatf("hold%0d_data", i), avm_writedata, e.data);
            check($sformatf("hold%0d_be", i), 64'(avm_byteenable), 64'(e.be));
            check($sformatf("hold%0d_busy", i), 64'(busy), 64'd1);
        end
        @(posedge clock);
        #1;
        wait_mode = 0;
        @(negedge clock);
        check("hold5_write", 64'(avm_write), 64'd1);
        check("hold5_addr", 64'(avm_address), 64'(e.addr));
        @(negedge clock);
        check("hold_write_released", 64'(avm_write), 64'd0);
        check("hold_one_accept", 64'(acc.size()), 64'd1);
        idle(2);

        // Off-screen pixel
        do_reset();
        buffer_sel = 1'b0;
        push(pix(640, 10, 32'h0F0F_0F0F), ok);
        idle(10);
`ifdef FB_PIXEL_WRITER_CLIP_EN
        check("clip_no_write", 64'(acc.size()), 64'd0);
        check("clip_drop", 64'(dropped_count), 64'd1);
`else
        check("noclip_write", 64'(acc.size()), 64'd1);
        if (acc.size() > 0) check("noclip_addr", 64'(acc[0].addr), 64'h0700_0DC0);
        check("noclip_drop", 64'(dropped_count), 64'd0);
`endif

        // Randomized pixels, random waitrequest
        do_reset();
        expq.delete();
        drop_exp   = 0;
        wait_mode  = 1;
        buffer_sel = 1'($urandom_range(0, 1));
        for (int i = 0; i < 40; i++) begin
            int x;
            int y;
            logic [31:0] c;
            x = $urandom_range(0, 700);
            y = $urandom_range(0, 10);
            c = $urandom;
            push_retry(pix(x, y, c), 200, ok);
            if (clipped(x, y)) drop_exp++;
            else expq.push_back(model(x, y, c, buffer_sel));
        end
        wait_acc(expq.size(), 500, "rand_count");
        idle(5);
        check("rand_count_final", 64'(acc.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < acc.size(); i++) begin
            check($sformatf("rand%0d_addr_be", i), {27'h0, acc[i].addr, acc[i].be},
                  {27'h0, expq[i].addr, expq[i].be});
            check($sformatf("rand%0d_data", i), acc[i].data, expq[i].data);
        end
        check("rand_drop", 64'(dropped_count), 64'(drop_exp));

        // Fill with pixels queued behind it
        do_reset();
        expq.delete();
        wait_mode   = 1;
        buffer_sel  = 1'b0;
        fill_colour = 32'h00FF00FF;
        fill_start  = 1'b1;
        idle(1);
        fill_start  = 1'b0;
        fill_colour = 32'hDEADBEEF;
        buffer_sel  = 1'b1;
        @(negedge clock);
        check("fill_busy", 64'(busy), 64'd1);
        idle(1);
        first_refuse = -1;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            int x;
            int y;
            logic [31:0] c;
            x = $urandom_range(0, W - 1);
            y = $urandom_range(0, H - 1);
            c = $urandom;
            push(pix(x, y, c), ok);
            if (!ok && first_refuse < 0) first_refuse = n_acc;
            if (!ok) push_retry(pix(x, y, c), 20000, ok);
            n_acc++;
            expq.push_back(model(x, y, c, 1'b1));
        end
        check("fill_fifo_full_at", 64'(first_refuse), 64'd16);
        wait_acc(WORDS + 20, 20000, "fill_total_writes");
        idle(4);
        check("fill_done_once", 64'(done_cnt), 64'd1);
        check("fill_idle_after", 64'(busy), 64'd0);
        if (acc.size() >= WORDS + 20) begin
            addr_err = 0;
            data_err = 0;
            for (int i = 0; i < WORDS; i++) begin
                if (acc[i].addr !== FB0 + 29'((i / 8) * 8) || acc[i].bc !== 8'd8) addr_err++;
                if (acc[i].data !== 64'h00FF00FF_00FF00FF || acc[i].be !== 8'hFF) data_err++;
            end
            check("fill_addr_errs", 64'(addr_err), 64'd0);
            check("fill_data_errs", 64'(data_err), 64'd0);
            check("fill_first_addr", 64'(acc[0].addr), 64'(FB0));
            check("fill_last_addr", 64'(acc[WORDS - 1].addr), 64'h0700_09F8);
            for (int i = 0; i < 20; i++) begin
                check($sformatf("fillpix%0d_addr_be", i),
                      {27'h0, acc[WORDS + i].addr, acc[WORDS + i].be},
                      {27'h0, expq[i].addr, expq[i].be});
                check($sformatf("fillpix%0d_data", i), acc[WORDS + i].data, expq[i].data);
            end
        end

        // Reset in the middle of a fill burst
        do_reset();
        wait_mode   = 0;
        buffer_sel  = 1'b0;
        fill_colour = 32'h1357_9BDF;
        fill_start  = 1'b1;
        idle(1);
        fill_start  = 1'b0;
        idle(30);
        for (int i = 0; i < 3; i++) push(pix(i, 1, 32'hFFFF_0000), ok);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_write_before", 64'(avm_write), 64'd1);
        @(negedge clock);
        check("midrst_write", 64'(avm_write), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(pixel_ready), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        acc.delete();
        idle(8);
        check("midrst_fifo_flushed", 64'(acc.size()), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);
        check("midrst_ready_back", 64'(pixel_ready), 64'd1);
        push(pix(5, 3, 32'h7777_8888), ok);
        wait_acc(1, 50, "midrst_new_count");
        if (acc.size() > 0) begin
            check("midrst_new_addr", 64'(acc[0].addr), 64'h0700_03C2);
            check("midrst_new_data", acc[0].data, 64'h7777_8888_0000_0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
